uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with runtime parity/stop-bit selection and a valid/ready holding register.
// Optional UART_RX_MAJORITY_EN: 3-tick majority vote at every sample point.
module uart_rx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_os,
  input  logic                 rx_pin,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits_2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  // Vote completes one tick after the nominal point, so every decision shifts by one tick.
  localparam int unsigned START_PT = OVERSAMPLE / 2;
`else
  localparam int unsigned START_PT = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [CNT_W-1:0] START_PT_C = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] BIT_PT_C   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     os_cnt, os_cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_en, par_en_nxt;
  logic                 par_odd, par_odd_nxt;
  logic                 stop2, stop2_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 parity_err_n, parity_err_n_nxt;
  logic                 ferr, ferr_nxt;
  logic                 deliver;

  logic sync1, sync2, rx_prev;
  logic sample;
  logic fall_edge;
  logic [CNT_W-1:0] cnt_inc;

  // Two-flop synchroniser; the edge-detect flop only advances on ticks so a one-clk edge is not missed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
      if (tick_os) rx_prev <= sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist <= 2'b11;
    else if (tick_os) hist <= {hist[0], sync2};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
  assign sample = sync2;
`endif

  assign fall_edge = rx_prev & ~sync2;
  assign cnt_inc   = (os_cnt == BIT_PT_C) ? '0 : os_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      stop2        <= 1'b0;
      stop_cnt     <= 1'b0;
      parity_err_n <= 1'b0;
      ferr         <= 1'b0;
    end else begin
      state        <= state_nxt;
      os_cnt       <= os_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shreg        <= shreg_nxt;
      par_en       <= par_en_nxt;
      par_odd      <= par_odd_nxt;
      stop2        <= stop2_nxt;
      stop_cnt     <= stop_cnt_nxt;
      parity_err_n <= parity_err_n_nxt;
      ferr         <= ferr_nxt;
    end
  end

  // Next-state and deframing datapath; nothing moves without a tick.
  always_comb begin
    state_nxt        = state;
    os_cnt_nxt       = os_cnt;
    bit_idx_nxt      = bit_idx;
    shreg_nxt        = shreg;
    par_en_nxt       = par_en;
    par_odd_nxt      = par_odd;
    stop2_nxt        = stop2;
    stop_cnt_nxt     = stop_cnt;
    parity_err_n_nxt = parity_err_n;
    ferr_nxt         = ferr;
    deliver          = 1'b0;

    if (tick_os) begin
      case (state)
        IDLE: begin
          if (fall_edge) begin
            par_en_nxt  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd_nxt = (parity_mode == 2'b01);
            stop2_nxt   = stop_bits_2;
            os_cnt_nxt  = '0;
            state_nxt   = START;
          end
        end
        START: begin
          if (os_cnt == START_PT_C) begin
            if (sample) begin
              state_nxt = IDLE;
            end else begin
              os_cnt_nxt       = '0;
              bit_idx_nxt      = '0;
              stop_cnt_nxt     = 1'b0;
              parity_err_n_nxt = 1'b0;
              ferr_nxt         = 1'b0;
              state_nxt        = DATA;
            end
          end else begin
            os_cnt_nxt = cnt_inc;
          end
        end
        DATA: begin
          os_cnt_nxt = cnt_inc;
          if (os_cnt == BIT_PT_C) begin
            shreg_nxt = {sample, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX_C) state_nxt = par_en ? PARITY : STOP;
            else                       bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
        PARITY: begin
          os_cnt_nxt = cnt_inc;
          if (os_cnt == BIT_PT_C) begin
            parity_err_n_nxt = (^shreg) ^ sample ^ par_odd;
            state_nxt        = STOP;
          end
        end
        STOP: begin
          os_cnt_nxt = cnt_inc;
          if (os_cnt == BIT_PT_C) begin
            if (!sample) ferr_nxt = 1'b1;
            if (stop2 && !stop_cnt) begin
              stop_cnt_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
              deliver   = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Holding register: a concurrent handshake frees the slot for the word being delivered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data     <= shreg;
        parity_err  <= parity_err_n;
        frame_err   <= ferr_nxt;
        overrun_err <= 1'b0;
        rx_valid    <= 1'b1;
      end else if (deliver) begin
        overrun_err <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
